// File: rtl/aes_pkg.sv
// Shared definitions for the AES key store: key-length encodings,
// zeroize FSM states and small helpers used by the key slots and the bank.
package aes_pkg;

  localparam logic [1:0] KLEN_128  = 2'd0;
  localparam logic [1:0] KLEN_192  = 2'd1;
  localparam logic [1:0] KLEN_256  = 2'd2;
  localparam logic [1:0] KLEN_RSVD = 2'd3;

  // Widest word bswap_word can handle; callers zero-extend into this.
  localparam int MAX_BSWAP_W = 256;

  typedef enum logic {
    ZS_IDLE  = 1'b0,
    ZS_SWEEP = 1'b1
  } zstate_t;

  // Number of 32-bit-sized words a committed length occupies.
  function automatic int klen_words(input logic [1:0] len);
    case (len)
      KLEN_128: return 4;
      KLEN_192: return 6;
      default:  return 8;
    endcase
  endfunction

  // Reverse the byte order inside the low ws bits of w; upper bits return 0.
  function automatic logic [MAX_BSWAP_W-1:0] bswap_word(
    input logic [MAX_BSWAP_W-1:0] w,
    input int                     ws
  );
    logic [MAX_BSWAP_W-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_BSWAP_W / 8; b++) begin
      if (b < ws / 8) r[b*8 +: 8] = w[(ws/8 - 1 - b)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/key_slot.sv
// One key slot: word storage plus valid/lock/length flags, and a
// big-endian, MSB-justified view of the key with unused words masked to 0.
module key_slot
  import aes_pkg::*;
#(
  parameter  int WORD_SIZE = 32,
  parameter  int MAX_WORDS = 8,
  parameter  int BYTE_SWAP = 1,
  localparam int IW        = $clog2(MAX_WORDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wen,
  input  logic [IW-1:0]                  widx,
  input  logic [WORD_SIZE-1:0]           wdata,
  input  logic                           commit,
  input  logic [1:0]                     clen,
  input  logic                           lock_in,
  input  logic                           clr,
  input  logic                           zwen,
  input  logic [IW-1:0]                  zidx,
  output logic                           valid,
  output logic                           lock,
  output logic [1:0]                     len,
  output logic [WORD_SIZE*MAX_WORDS-1:0] key
);

  logic [WORD_SIZE-1:0] mem [MAX_WORDS];

  // Host word to output byte order.
  function automatic logic [WORD_SIZE-1:0] host_to_be(input logic [WORD_SIZE-1:0] w);
    if (BYTE_SWAP != 0) return WORD_SIZE'(bswap_word(MAX_BSWAP_W'(w), WORD_SIZE));
    return w;
  endfunction

  // Word storage: the zeroize sweep has priority over host writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_WORDS; i++) mem[i] <= '0;
    end else if (zwen) begin
      mem[zidx] <= '0;
    end else if (wen) begin
      mem[widx] <= wdata;
    end
  end

  // Slot flags: zeroize clear beats commit, commit beats the write's invalidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      lock  <= 1'b0;
      len   <= KLEN_128;
    end else if (clr) begin
      valid <= 1'b0;
      lock  <= 1'b0;
      len   <= KLEN_128;
    end else if (commit) begin
      valid <= 1'b1;
      lock  <= lock_in;
      len   <= clen;
    end else if (wen) begin
      valid <= 1'b0;
    end
  end

  // Assemble word 0 at the top; words beyond the committed length read 0.
  always_comb begin
    key = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (k < klen_words(len))
        key[(MAX_WORDS-1-k)*WORD_SIZE +: WORD_SIZE] = host_to_be(mem[k]);
    end
  end

endmodule

// File: rtl/key_bank.sv
// Multi-slot AES key store: host write/commit with locking, registered
// whole-key read port, and a word-by-word zeroize sweep.
module key_bank
  import aes_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int MAX_WORDS = 8,
  parameter int SLOTS     = 4,
  parameter int BYTE_SWAP = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wen,
  input  logic [$clog2(SLOTS)-1:0]       wslot,
  input  logic [$clog2(MAX_WORDS)-1:0]   widx,
  input  logic [WORD_SIZE-1:0]           wdata,
  input  logic                           commit,
  input  logic [1:0]                     clen,
  input  logic                           clock_in,
  input  logic                           zeroize,
  input  logic                           rd_req,
  input  logic [$clog2(SLOTS)-1:0]       rd_slot,
  output logic                           rd_valid,
  output logic                           rd_hit,
  output logic [1:0]                     rd_len,
  output logic [WORD_SIZE*MAX_WORDS-1:0] rd_key,
  output logic                           busy,
  output logic                           wr_err
);

  localparam int SW    = $clog2(SLOTS);
  localparam int IW    = $clog2(MAX_WORDS);
  localparam int KW    = WORD_SIZE * MAX_WORDS;
  localparam int TOTAL = SLOTS * MAX_WORDS;
  localparam int CW    = $clog2(TOTAL);

  zstate_t         state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            clr_all;
  logic [SW-1:0]   zslot;
  logic [IW-1:0]   zidx;

  logic [SLOTS-1:0] valid_v, lock_v;
  logic [1:0]       len_v [SLOTS];
  logic [KW-1:0]    key_v [SLOTS];

  logic slot_ok, idx_ok, rd_ok;
  logic wr_ok, cm_ok, err_d, hit_d;

  assign slot_ok = 32'(wslot) < SLOTS;
  assign idx_ok  = 32'(widx) < MAX_WORDS;
  assign rd_ok   = 32'(rd_slot) < SLOTS;

  assign wr_ok = wen && slot_ok && idx_ok && !lock_v[wslot] && !busy;
  assign cm_ok = commit && slot_ok && !lock_v[wslot] && !busy && (clen != KLEN_RSVD);
  assign err_d = (wen && !wr_ok) || (commit && !cm_ok);
  assign hit_d = rd_ok && valid_v[rd_slot] && !busy;

  assign last  = cnt == CW'(TOTAL - 1);
  assign zslot = SW'(32'(cnt) / MAX_WORDS);
  assign zidx  = IW'(32'(cnt) % MAX_WORDS);

  // Zeroize FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ZS_IDLE;
    else     state <= state_nxt;
  end

  // Zeroize FSM next state; a zeroize pulse while sweeping is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ZS_IDLE:  if (zeroize) state_nxt = ZS_SWEEP;
      ZS_SWEEP: if (last)    state_nxt = ZS_IDLE;
      default:               state_nxt = ZS_IDLE;
    endcase
  end

  // Zeroize FSM outputs: flags drop on entry, busy covers the sweep cycles.
  always_comb begin
    busy    = (state == ZS_SWEEP);
    clr_all = (state == ZS_IDLE) && zeroize;
  end

  // Sweep counter walks slot-major over every word, parked at 0 when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (state == ZS_IDLE)   cnt <= '0;
    else if (last)               cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    logic sel;
    assign sel = (32'(wslot) == g);
    key_slot #(
      .WORD_SIZE (WORD_SIZE),
      .MAX_WORDS (MAX_WORDS),
      .BYTE_SWAP (BYTE_SWAP)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wen     (wr_ok && sel),
      .widx    (widx),
      .wdata   (wdata),
      .commit  (cm_ok && sel),
      .clen    (clen),
      .lock_in (clock_in),
      .clr     (clr_all),
      .zwen    (busy && (32'(zslot) == g)),
      .zidx    (zidx),
      .valid   (valid_v[g]),
      .lock    (lock_v[g]),
      .len     (len_v[g]),
      .key     (key_v[g])
    );
  end

  // Registered read port and write-error pulse; read data holds between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_len   <= '0;
      rd_key   <= '0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      wr_err   <= err_d;
      if (rd_req) begin
        rd_hit <= hit_d;
        rd_len <= hit_d ? len_v[rd_slot] : 2'd0;
        rd_key <= hit_d ? key_v[rd_slot] : '0;
      end
    end
  end

endmodule

// File: tb/tb_key_bank.sv
// Directed bench for key_bank: a vector table for single-cycle write/commit/
// read behaviour, then hand sequences for zeroize timing and mid-sweep reset.
module tb_key_bank;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wen = 1'b0;
  logic [1:0]   wslot = '0;
  logic [2:0]   widx = '0;
  logic [31:0]  wdata = '0;
  logic         commit = 1'b0;
  logic [1:0]   clen = '0;
  logic         clock_in = 1'b0;
  logic         zeroize = 1'b0;
  logic         rd_req = 1'b0;
  logic [1:0]   rd_slot = '0;
  logic         rd_valid, rd_hit, busy, wr_err;
  logic [1:0]   rd_len;
  logic [255:0] rd_key;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cycles;

  key_bank dut (
    .clk(clk), .rst(rst), .wen(wen), .wslot(wslot), .widx(widx), .wdata(wdata),
    .commit(commit), .clen(clen), .clock_in(clock_in), .zeroize(zeroize),
    .rd_req(rd_req), .rd_slot(rd_slot), .rd_valid(rd_valid), .rd_hit(rd_hit),
    .rd_len(rd_len), .rd_key(rd_key), .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         wen;
    logic [1:0]   ws;
    logic [2:0]   wi;
    logic [31:0]  wd;
    logic         cm;
    logic [1:0]   cl;
    logic         lk;
    logic         rq;
    logic [1:0]   rs;
    logic         exp_err;
    logic         exp_hit;
    logic [1:0]   exp_len;
    logic [255:0] exp_key;
    string        name;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic w, input logic [1:0] ws, input logic [2:0] wi,
                              input logic [31:0] wd, input logic cm, input logic [1:0] cl,
                              input logic lk, input logic rq, input logic [1:0] rs,
                              input logic ee, input logic eh, input logic [1:0] el,
                              input logic [255:0] ek, input string nm);
    vec_t v;
    v.wen = w; v.ws = ws; v.wi = wi; v.wd = wd; v.cm = cm; v.cl = cl; v.lk = lk;
    v.rq = rq; v.rs = rs; v.exp_err = ee; v.exp_hit = eh; v.exp_len = el;
    v.exp_key = ek; v.name = nm;
    return v;
  endfunction

  function automatic vec_t wr(input logic [1:0] s, input logic [2:0] i, input logic [31:0] d,
                              input logic ee, input string nm);
    return mk(1, s, i, d, 0, 0, 0, 0, 0, ee, 0, 0, '0, nm);
  endfunction

  function automatic vec_t cm(input logic [1:0] s, input logic [1:0] cl, input logic lk,
                              input logic ee, input string nm);
    return mk(0, s, 0, 0, 1, cl, lk, 0, 0, ee, 0, 0, '0, nm);
  endfunction

  function automatic vec_t rd(input logic [1:0] s, input logic eh, input logic [1:0] el,
                              input logic [255:0] ek, input string nm);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, s, 0, eh, el, ek, nm);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 0; commit = 0; zeroize = 0; rd_req = 0; clock_in = 0;
  endtask

  localparam logic [255:0] K1  = {128'h000102030405060708090A0B0C0D0E0F, 128'h0};
  localparam logic [255:0] K2A = {32'h20202020, 32'h21212121, 32'h22222222, 32'h23232323,
                                  32'h24242424, 32'h25252525, 64'h0};
  localparam logic [255:0] K2B = {32'hFFFFFFFF, 32'h21212121, 32'h22222222, 32'h23232323,
                                  32'h24242424, 32'h25252525, 32'h26262626, 32'h27272727};
  localparam logic [255:0] K0  = {32'h40404040, 32'h41414141, 32'h42424242, 32'h43434343, 128'h0};
  localparam logic [255:0] K3  = {32'h60606060, 32'h61616161, 32'h62626262, 32'h63636363, 128'h0};
  localparam logic [255:0] K3B = {32'h77777777, 32'h88888888, 32'h62626262, 32'h63636363, 128'h0};

  initial begin
    logic [7:0] b;

    // Vector table.
    vq.push_back(rd(0, 0, 0, '0, "rd_empty_s0"));
    vq.push_back(wr(1, 0, 32'h03020100, 0, "t1_w0"));
    vq.push_back(wr(1, 1, 32'h07060504, 0, "t1_w1"));
    vq.push_back(wr(1, 2, 32'h0B0A0908, 0, "t1_w2"));
    vq.push_back(wr(1, 3, 32'h0F0E0D0C, 0, "t1_w3"));
    vq.push_back(rd(1, 0, 0, '0, "t1_rd_uncommitted"));
    vq.push_back(cm(1, KLEN_128, 0, 0, "t1_commit"));
    vq.push_back(rd(1, 1, 0, K1, "t1_rd128"));
    for (int k = 0; k < 8; k++) begin
      b = 8'h20 + 8'(k);
      vq.push_back(wr(2, 3'(k), {4{b}}, 0, "t2_w"));
    end
    vq.push_back(cm(2, KLEN_192, 0, 0, "t2_commit192"));
    vq.push_back(rd(2, 1, 1, K2A, "t2_rd192"));
    vq.push_back(wr(2, 0, 32'hFFFFFFFF, 0, "t2_rewrite"));
    vq.push_back(rd(2, 0, 0, '0, "t2_rd_after_rewrite"));
    vq.push_back(cm(2, KLEN_256, 0, 0, "t2_commit256"));
    vq.push_back(rd(2, 1, 2, K2B, "t2_rd256"));
    for (int k = 0; k < 4; k++) begin
      b = 8'h40 + 8'(k);
      vq.push_back(wr(0, 3'(k), {4{b}}, 0, "t3_w"));
    end
    vq.push_back(cm(0, KLEN_128, 1, 0, "t3_commit_lock"));
    vq.push_back(rd(0, 1, 0, K0, "t3_rd_locked"));
    vq.push_back(wr(0, 0, 32'h0, 1, "t3_wr_locked"));
    vq.push_back(rd(0, 1, 0, K0, "t3_rd_unchanged"));
    vq.push_back(cm(0, KLEN_128, 0, 1, "t3_commit_locked"));
    vq.push_back(cm(3, KLEN_RSVD, 0, 1, "t3_commit_rsvd"));
    for (int k = 0; k < 4; k++) begin
      b = 8'h60 + 8'(k);
      vq.push_back(wr(3, 3'(k), {4{b}}, 0, "t6_w"));
    end
    vq.push_back(cm(3, KLEN_128, 0, 0, "t6_commit"));
    vq.push_back(mk(1, 3, 0, 32'h77777777, 0, 0, 0, 1, 3, 0, 1, 0, K3, "t6_wr_rd_same"));
    vq.push_back(rd(3, 0, 0, '0, "t6_rd_invalidated"));
    vq.push_back(mk(1, 3, 1, 32'h88888888, 1, KLEN_128, 0, 0, 0, 0, 0, 0, '0, "t6_wr_commit"));
    vq.push_back(rd(3, 1, 0, K3B, "t6_rd_new"));

    // Reset state.
    idle();
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_hit", rd_hit, 0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_rd_key", rd_key, 0);
    chk("rst_wr_err", wr_err, 0);
    rst = 0;
    tick();

    foreach (vq[i]) begin
      wen = vq[i].wen; wslot = vq[i].ws; widx = vq[i].wi; wdata = vq[i].wd;
      commit = vq[i].cm; clen = vq[i].cl; clock_in = vq[i].lk;
      rd_req = vq[i].rq; rd_slot = vq[i].rs;
      tick();
      chk({vq[i].name, ".wr_err"}, wr_err, vq[i].exp_err);
      chk({vq[i].name, ".rd_valid"}, rd_valid, vq[i].rq);
      if (vq[i].rq) begin
        chk({vq[i].name, ".rd_hit"}, rd_hit, vq[i].exp_hit);
        chk({vq[i].name, ".rd_len"}, rd_len, vq[i].exp_len);
        chk({vq[i].name, ".rd_key"}, rd_key, vq[i].exp_key);
      end
    end
    idle();

    // Read results hold after the valid pulse.
    tick();
    chk("hold_rd_valid", rd_valid, 0);
    chk("hold_rd_key", rd_key, K3B);
    chk("hold_rd_hit", rd_hit, 1);

    // Zeroize with every slot valid; extra zeroize, read and write mid-sweep.
    zeroize = 1;
    tick();
    zeroize = 0;
    busy_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy) break;
      busy_cycles++;
      rd_req = (c == 3); rd_slot = 2'd1;
      zeroize = (c == 5);
      wen = (c == 7); wslot = 2'd0; widx = 3'd0; wdata = 32'hDEADBEEF;
      tick();
      if (c == 3) begin
        chk("zb_rd_valid", rd_valid, 1);
        chk("zb_rd_hit", rd_hit, 0);
        chk("zb_rd_key", rd_key, 0);
      end
      if (c == 7) chk("zb_wr_err", wr_err, 1);
    end
    idle();
    chk("zb_busy_cycles", busy_cycles, 32);

    for (int s = 0; s < 4; s++) begin
      rd_req = 1; rd_slot = 2'(s);
      tick();
      chk("zb_post_rd_hit", rd_hit, 0);
      chk("zb_post_rd_key", rd_key, 0);
    end
    rd_req = 0;
    wen = 1; wslot = 0; widx = 0; wdata = 32'h03020100;
    tick();
    wen = 0;
    chk("zb_unlock_wr_err", wr_err, 0);
    commit = 1; wslot = 0; clen = KLEN_128; clock_in = 0;
    tick();
    commit = 0;
    chk("zb_unlock_cm_err", wr_err, 0);
    rd_req = 1; rd_slot = 0;
    tick();
    rd_req = 0;
    chk("zb_s0_hit", rd_hit, 1);
    chk("zb_s0_key", rd_key, {32'h00010203, 224'h0});

    // Reset in the middle of a sweep.
    wen = 1; wslot = 1; widx = 0; wdata = 32'h11111111;
    tick();
    wen = 0; commit = 1; clen = KLEN_128;
    tick();
    commit = 0; rd_req = 1; rd_slot = 1;
    tick();
    rd_req = 0;
    chk("mr_pre_key", rd_key, {32'h11111111, 224'h0});
    zeroize = 1;
    tick();
    zeroize = 0;
    repeat (9) tick();
    chk("mr_busy_before", busy, 1);
    rst = 1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_rd_hit", rd_hit, 0);
    chk("mr_rd_len", rd_len, 0);
    chk("mr_rd_key", rd_key, 0);
    chk("mr_rd_valid", rd_valid, 0);
    chk("mr_wr_err", wr_err, 0);
    tick();
    rst = 0;
    rd_req = 1; rd_slot = 1;
    tick();
    rd_req = 0;
    chk("mr_post_hit", rd_hit, 0);
    chk("mr_post_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_bank.md
Name: key_bank

Overview:
- Multi-slot key store for the AES datapath, holding up to SLOTS independent keys of 128/192/256 bits.
- The host loads keys one word at a time, then commits each slot with a key length and an optional lock.
- The key-expansion engine reads a whole slot as a big-endian, left-justified vector with one-cycle latency.
- A hardware zeroize sweep wipes every slot word by word.

Parameters:
- WORD_SIZE, 32, bits per host write word; must be a multiple of 8.
- MAX_WORDS, 8, words per slot; 8 x 32 = 256-bit maximum key.
- SLOTS, 4, number of independent key slots.
- BYTE_SWAP, 1, 1 = convert little-endian host words to big-endian output bytes; 0 = pass through.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wen  in  1  write strobe
- wslot  in  $clog2(SLOTS)  slot addressed by wen/commit
- widx  in  $clog2(MAX_WORDS)  word index within slot
- wdata  in  WORD_SIZE  write data
- commit  in  1  pulse: mark wslot valid with length clen
- clen  in  2  0=128b, 1=192b, 2=256b, 3=reserved
- clock_in  in  1  sampled with commit; 1 = lock slot
- zeroize  in  1  pulse: start full wipe
- rd_req  in  1  read request
- rd_slot  in  $clog2(SLOTS)  slot to read
- rd_valid  out  1  pulse one cycle after rd_req
- rd_hit  out  1  slot valid and not busy at request
- rd_len  out  2  committed clen of slot
- rd_key  out  WORD_SIZE*MAX_WORDS  key, MSB-justified
- busy  out  1  zeroize sweep in progress
- wr_err  out  1  one-cycle pulse on rejected write/commit

Behaviour:
- Reset: all storage words, per-slot valid/lock/len, rd_valid, rd_hit, rd_len, rd_key, busy and wr_err = 0. Reset overrides a sweep in progress.
- Write rules:
  - wen with slot unlocked and not busy: store wdata at [wslot][widx] and clear valid[wslot].
  - Locked slot or busy: no store; wr_err=1 next cycle.
- Commit rules:
  - commit with slot unlocked, not busy and clen!=3: valid=1, len=clen, lock=clock_in.
  - Otherwise reject with wr_err=1.
  - wen and commit on the same slot in the same cycle: the word is stored and commit wins, so valid=1.
- Read path (registered, latency 1):
  - rd_req in cycle N gives rd_valid=1 in cycle N+1 with rd_hit/rd_len/rd_key reflecting state before any write in cycle N.
  - Miss (slot invalid, or busy in cycle N): rd_hit=0, rd_key=0, rd_len=0. Partial keys are never exposed.
  - rd_key assembly: word 0 occupies the top WORD_SIZE bits and word k sits below word k-1.
  - With BYTE_SWAP=1, bytes are swapped within each word, so the first host byte becomes the MSB of the vector.
  - Words at index >= 4+2*len are forced to 0 (128b: words 4..7 zero; 192b: words 6..7 zero).
  - rd_key/rd_len/rd_hit hold until the next rd_req; rd_valid is a single-cycle pulse.
- Zeroize FSM, states IDLE and SWEEP:
  - IDLE --zeroize--> SWEEP: valid and lock of all slots cleared in the transition cycle; busy=1 from the next cycle.
  - SWEEP: a counter over SLOTS*MAX_WORDS writes 0 to one word per cycle (slot-major).
  - At the last word, SWEEP --> IDLE; busy deasserts the cycle after the final clear, SLOTS*MAX_WORDS cycles total.
  - zeroize while busy is ignored; the counter does not restart.
  - zeroize is the only way to unlock a slot.
- widx and wslot are always in range when SLOTS and MAX_WORDS are powers of two. Otherwise out-of-range addresses are rejected with wr_err.

Decomposition:
- Shared package aes_pkg:
  - KLEN_128/192/256/RSVD encodings.
  - Function klen_words(len) returning 4/6/8.
  - Function bswap_word(w, WORD_SIZE).
- One natural sub-module, key_slot: storage for one slot plus valid/lock/len, write and zeroize-clear ports, and a masked big-endian output. key_bank instantiates SLOTS copies and adds the FSM, read mux and error logic.

Test Plan:
- Write slot 1 words 0..3 = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, then commit clen=0 and read slot 1 -> rd_hit=1, rd_len=0, rd_key[255:128]=0x000102030405060708090A0B0C0D0E0F, rd_key[127:0]=0.
- Load 8 words into slot 2, commit clen=1, read -> words 6..7 read 0; rewrite widx=0, read -> rd_hit=0, rd_key=0.
- Commit slot 0 with clock_in=1, then wen to slot 0 -> wr_err pulse, contents unchanged; commit slot 0 with clen=3 -> wr_err.
- Valid keys in all slots, pulse zeroize -> busy high for exactly 32 cycles. rd_req during busy -> rd_hit=0; after busy falls, every slot reads miss and slot 0 accepts writes again.
- Assert rst mid-sweep (cycle 10) -> busy=0 and all outputs 0 immediately; zeroize pulse during busy -> sweep still ends at cycle 32.
- Same-cycle wen+rd_req on slot 3 (valid key) -> read returns old key with hit=1; same-cycle wen+commit -> new word present and valid=1.
